mem_w_port: RTL and testbench

//  Memory-side end of the W-register MR/MW path. Accepts a one-shot read/write request from
//  the control unit and runs a wait-state-tolerant handshake with data memory. On reads it

---
 rtl/mem_w_port.sv | 91 +++++++++
 tb/tb_mem_w_port.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_w_port.sv
// Memory-side end of the W-register MR/MW path: one-shot read/write request,
// wait-state-tolerant handshake with data memory, and a cycle-count timeout.
module mem_w_port #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_rd,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] w_out,
   output logic [DATA_W-1:0] w_in,
   output logic              w_load,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_en,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t        state;
   logic          op_rd;
   logic          err_r;
   logic [CW-1:0] wait_cnt;

   // Handshake: a request is taken only in IDLE; the memory side sees mem_en
   // for the whole ACCESS phase and completes it with mem_ack at any edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         op_rd     <= 1'b0;
         err_r     <= 1'b0;
         wait_cnt  <= '0;
         w_in      <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_rd || req_wr) begin
                  op_rd     <= req_rd;
                  mem_addr  <= addr;
                  mem_wdata <= w_out;
                  wait_cnt  <= '0;
                  err_r     <= 1'b0;
                  state     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               // Ack on the timeout edge still counts as success.
               if (mem_ack) begin
                  if (op_rd) w_in <= mem_rdata;
                  err_r <= 1'b0;
                  state <= S_DONE;
               end else if (wait_cnt == LAST) begin
                  err_r <= 1'b1;
                  state <= S_DONE;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Decoded straight from the state register so reset drops them at once.
   assign busy   = (state != S_IDLE);
   assign mem_en = (state == S_ACCESS);
   assign mem_we = (state == S_ACCESS) && !op_rd;
   assign done   = (state == S_DONE);
   assign err    = (state == S_DONE) && err_r;
   assign w_load = (state == S_DONE) && op_rd && !err_r;

endmodule

// File: tb/tb_mem_w_port.sv
// Directed bench for mem_w_port: two instances (TIMEOUT=8 and TIMEOUT=2)
// share stimulus; outputs are checked at the falling edge.
module tb_mem_w_port;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_rd, req_wr, mem_ack;
   logic [7:0]  addr;
   logic [15:0] w_out, mem_rdata;

   logic [15:0] w_in, mem_wdata, w_in2, mem_wdata2;
   logic [7:0]  mem_addr, mem_addr2;
   logic        w_load, busy, done, err, mem_en, mem_we;
   logic        w_load2, busy2, done2, err2, mem_en2, mem_we2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_w_port #(.DATA_W(16), .ADDR_W(8), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .addr(addr),
      .w_out(w_out), .w_in(w_in), .w_load(w_load), .busy(busy), .done(done),
      .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en),
      .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   mem_w_port #(.DATA_W(16), .ADDR_W(8), .TIMEOUT(2)) dut2 (
      .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .addr(addr),
      .w_out(w_out), .w_in(w_in2), .w_load(w_load2), .busy(busy2), .done(done2),
      .err(err2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_en(mem_en2),
      .mem_we(mem_we2), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; req_rd = 0; req_wr = 0; mem_ack = 0;
      addr = '0; w_out = '0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_mem_en", mem_en, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_w_in", w_in, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      reset = 1'b0;
      tick();

      // 1. zero-wait write
      req_wr = 1; addr = 8'h12; w_out = 16'hBEEF; mem_ack = 1;
      tick();
      req_wr = 0; w_out = 16'h0000;
      check_eq("t1_mem_en", mem_en, 1);
      check_eq("t1_mem_we", mem_we, 1);
      check_eq("t1_mem_addr", mem_addr, 8'h12);
      check_eq("t1_mem_wdata", mem_wdata, 16'hBEEF);
      tick();
      mem_ack = 0;
      check_eq("t1_done", done, 1);
      check_eq("t1_err", err, 0);
      check_eq("t1_w_load", w_load, 0);
      check_eq("t1_mem_we_off", mem_we, 0);
      check_eq("t1_busy_done", busy, 1);
      tick();
      check_eq("t1_idle_busy", busy, 0);
      check_eq("t1_idle_done", done, 0);

      // 2. read with 3 wait states
      begin
         int busy_cycles = 0;
         req_rd = 1; addr = 8'h40;
         tick();
         req_rd = 0;
         for (int i = 0; i < 4; i++) begin
            check_eq("t2_mem_en", mem_en, 1);
            check_eq("t2_mem_we", mem_we, 0);
            check_eq("t2_done_low", done, 0);
            if (busy) busy_cycles++;
            if (i == 3) begin mem_ack = 1; mem_rdata = 16'h1234; end
            tick();
         end
         mem_ack = 0; mem_rdata = 16'h0;
         check_eq("t2_done", done, 1);
         check_eq("t2_w_load", w_load, 1);
         check_eq("t2_err", err, 0);
         check_eq("t2_w_in", w_in, 16'h1234);
         check_eq("t2_mem_en_off", mem_en, 0);
         if (busy) busy_cycles++;
         tick();
         check_eq("t2_busy_cycles", busy_cycles, 5);
         check_eq("t2_idle", busy, 0);
         check_eq("t2_w_load_pulse", w_load, 0);
         check_eq("t2_w_in_hold", w_in, 16'h1234);
      end

      // 3. timeout with TIMEOUT=8
      req_rd = 1; addr = 8'h41;
      tick();
      req_rd = 0;
      for (int i = 0; i < 8; i++) begin
         check_eq("t3_mem_en", mem_en, 1);
         check_eq("t3_done_low", done, 0);
         check_eq("t3_err_low", err, 0);
         tick();
      end
      check_eq("t3_done", done, 1);
      check_eq("t3_err", err, 1);
      check_eq("t3_w_load", w_load, 0);
      check_eq("t3_mem_en_off", mem_en, 0);
      check_eq("t3_w_in_kept", w_in, 16'h1234);
      tick();
      check_eq("t3_err_pulse", err, 0);
      check_eq("t3_idle", busy, 0);

      // 4. collision: read wins; requests while busy are dropped
      req_rd = 1; req_wr = 1; addr = 8'h33; w_out = 16'h7777;
      tick();
      req_rd = 0;
      check_eq("t4_mem_en", mem_en, 1);
      check_eq("t4_mem_we", mem_we, 0);
      mem_ack = 1; mem_rdata = 16'h5555;
      tick();
      check_eq("t4_done", done, 1);
      check_eq("t4_w_load", w_load, 1);
      check_eq("t4_w_in", w_in, 16'h5555);
      tick();
      req_wr = 0; mem_ack = 0;
      check_eq("t4_no_restart", busy, 0);
      check_eq("t4_no_mem_en", mem_en, 0);
      tick();
      check_eq("t4_still_idle", busy, 0);

      // 5. reset in the 2nd ACCESS cycle of a read
      req_rd = 1; addr = 8'h50;
      tick();
      req_rd = 0;
      tick();
      check_eq("t5_mem_en_pre", mem_en, 1);
      #2 reset = 1'b1;
      #1;
      check_eq("t5_mem_en_async", mem_en, 0);
      check_eq("t5_busy_async", busy, 0);
      check_eq("t5_done_async", done, 0);
      check_eq("t5_w_in_clr", w_in, 0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      check_eq("t5_no_done", done, 0);
      check_eq("t5_no_w_load", w_load, 0);
      req_wr = 1; addr = 8'h77; w_out = 16'hCAFE; mem_ack = 1;
      tick();
      req_wr = 0;
      check_eq("t5_wr_mem_we", mem_we, 1);
      check_eq("t5_wr_addr", mem_addr, 8'h77);
      check_eq("t5_wr_wdata", mem_wdata, 16'hCAFE);
      tick();
      mem_ack = 0;
      check_eq("t5_wr_done", done, 1);
      check_eq("t5_wr_err", err, 0);
      check_eq("t5_wr_w_load", w_load, 0);
      tick();

      // 6. ack on the timeout edge, TIMEOUT=2 instance
      req_rd = 1; addr = 8'h60;
      tick();
      req_rd = 0;
      check_eq("t6_mem_en_1", mem_en2, 1);
      tick();
      check_eq("t6_mem_en_2", mem_en2, 1);
      mem_ack = 1; mem_rdata = 16'hA5A5;
      tick();
      mem_ack = 0; mem_rdata = 16'h0;
      check_eq("t6_done", done2, 1);
      check_eq("t6_err", err2, 0);
      check_eq("t6_w_load", w_load2, 1);
      check_eq("t6_w_in", w_in2, 16'hA5A5);
      tick();

      // TIMEOUT=2 instance with no ack: aborts after exactly 2 ACCESS cycles
      req_rd = 1; addr = 8'h61;
      tick();
      req_rd = 0;
      check_eq("t7_mem_en_1", mem_en2, 1);
      tick();
      check_eq("t7_mem_en_2", mem_en2, 1);
      tick();
      check_eq("t7_done", done2, 1);
      check_eq("t7_err", err2, 1);
      check_eq("t7_w_in_kept", w_in2, 16'hA5A5);
      repeat (8) tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
